// File: rtl/ecc_scalar_mult_ctrl_if.sv
// Bundle of command-side and point-unit-side signals for the scalar-multiply sequencer.
// The slave view belongs to the sequencer; the master view belongs to whatever drives it.
interface ecc_scalar_mult_ctrl_if #(
    parameter int M = 163
);
    logic         start;
    logic [M-1:0] k;
    logic [M-1:0] px;
    logic [M-1:0] py;
    logic         busy;
    logic         done;
    logic         inf;
    logic         err;
    logic [M-1:0] x_out;
    logic [M-1:0] y_out;
    logic [M-1:0] z_out;
    logic [3:0]   dbg_state;

    logic         dbl_start;
    logic [M-1:0] dbl_x;
    logic [M-1:0] dbl_y;
    logic [M-1:0] dbl_z;
    logic         dbl_done;
    logic [M-1:0] dbl_xo;
    logic [M-1:0] dbl_yo;
    logic [M-1:0] dbl_zo;

    logic         add_start;
    logic [M-1:0] add_x0;
    logic [M-1:0] add_y0;
    logic [M-1:0] add_z0;
    logic [M-1:0] add_x1;
    logic [M-1:0] add_y1;
    logic         add_done;
    logic [M-1:0] add_x2;
    logic [M-1:0] add_y2;
    logic [M-1:0] add_z2;

    // Handshake: *_start is a one-cycle pulse; operands stay stable until the matching
    // *_done pulse, whose result bus is sampled only in that cycle. done/inf/err are a
    // one-cycle completion report; start is honoured only while busy is low and done is low.
    modport slave (
        input  start, k, px, py,
        input  dbl_done, dbl_xo, dbl_yo, dbl_zo,
        input  add_done, add_x2, add_y2, add_z2,
        output busy, done, inf, err, x_out, y_out, z_out, dbg_state,
        output dbl_start, dbl_x, dbl_y, dbl_z,
        output add_start, add_x0, add_y0, add_z0, add_x1, add_y1
    );

    modport master (
        output start, k, px, py,
        output dbl_done, dbl_xo, dbl_yo, dbl_zo,
        output add_done, add_x2, add_y2, add_z2,
        input  busy, done, inf, err, x_out, y_out, z_out, dbg_state,
        input  dbl_start, dbl_x, dbl_y, dbl_z,
        input  add_start, add_x0, add_y0, add_z0, add_x1, add_y1
    );
endinterface

// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Lopez-Dahab scalar multiplication Q = k*P.
// Holds k, P and the running point Q; all field arithmetic lives in the external units.
module ecc_scalar_mult_ctrl #(
    parameter int M       = 163,
    parameter int TIMEOUT = 255
) (
    input logic                   clk,
    input logic                   rst,
    ecc_scalar_mult_ctrl_if.slave bus
);
    localparam int IW = $clog2(M);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE, S_SCAN, S_DBL_GO, S_DBL_WAIT, S_DBL_NEXT,
        S_ADD_GO, S_ADD_WAIT, S_ADD_NEXT, S_FIN
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [M-1:0]  r_k, r_px, r_py;
    logic [M-1:0]  r_qx, r_qy, r_qz, w_qx, w_qy, w_qz;
    logic [M-1:0]  r_xo, r_yo, r_zo;
    logic [IW-1:0] r_i, w_i;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_inf, r_err, w_inf, w_err, w_cap;
    logic          w_bit, w_last;

    assign w_bit  = r_k[r_i];
    assign w_last = (r_i == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_qx        = r_qx;
        w_qy        = r_qy;
        w_qz        = r_qz;
        w_i         = r_i;
        w_cnt       = r_cnt;
        w_inf       = r_inf;
        w_err       = r_err;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_cap       = 1'b1;
                    w_i         = IW'(M - 1);
                    w_inf       = 1'b0;
                    w_err       = 1'b0;
                    w_state_nxt = S_SCAN;
                end
            end
            // Leading zeros cost one cycle each; the first set bit seeds Q with P.
            S_SCAN: begin
                if (w_bit) begin
                    w_qx = r_px;
                    w_qy = r_py;
                    w_qz = ONE;
                    if (w_last) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_i         = r_i - IW'(1);
                        w_state_nxt = S_DBL_GO;
                    end
                end else if (w_last) begin
                    w_inf       = 1'b1;
                    w_qx        = ONE;
                    w_qy        = '0;
                    w_qz        = '0;
                    w_state_nxt = S_FIN;
                end else begin
                    w_i = r_i - IW'(1);
                end
            end
            S_DBL_GO: begin
                w_cnt       = '0;
                w_state_nxt = S_DBL_WAIT;
            end
            S_DBL_WAIT: begin
                if (bus.dbl_done) begin
                    w_qx        = bus.dbl_xo;
                    w_qy        = bus.dbl_yo;
                    w_qz        = bus.dbl_zo;
                    w_state_nxt = S_DBL_NEXT;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_FIN;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_DBL_NEXT: begin
                if (w_bit) begin
                    w_state_nxt = S_ADD_GO;
                end else if (w_last) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_i         = r_i - IW'(1);
                    w_state_nxt = S_DBL_GO;
                end
            end
            S_ADD_GO: begin
                w_cnt       = '0;
                w_state_nxt = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (bus.add_done) begin
                    w_qx        = bus.add_x2;
                    w_qy        = bus.add_y2;
                    w_qz        = bus.add_z2;
                    w_state_nxt = S_ADD_NEXT;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_FIN;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_ADD_NEXT: begin
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_i         = r_i - IW'(1);
                    w_state_nxt = S_DBL_GO;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_qx    <= '0;
            r_qy    <= '0;
            r_qz    <= '0;
            r_xo    <= '0;
            r_yo    <= '0;
            r_zo    <= '0;
            r_i     <= '0;
            r_cnt   <= '0;
            r_inf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_qx    <= w_qx;
            r_qy    <= w_qy;
            r_qz    <= w_qz;
            r_i     <= w_i;
            r_cnt   <= w_cnt;
            r_inf   <= w_inf;
            r_err   <= w_err;
            if (w_cap) begin
                r_k  <= bus.k;
                r_px <= bus.px;
                r_py <= bus.py;
            end
            // Result registers load on the way into FIN so they are valid alongside done.
            if (w_state_nxt == S_FIN) begin
                r_xo <= w_qx;
                r_yo <= w_qy;
                r_zo <= w_qz;
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_FIN);
    assign bus.done      = (r_state == S_FIN);
    assign bus.inf       = r_inf;
    assign bus.err       = r_err;
    assign bus.x_out     = r_xo;
    assign bus.y_out     = r_yo;
    assign bus.z_out     = r_zo;
    assign bus.dbg_state = r_state;
    assign bus.dbl_start = (r_state == S_DBL_GO);
    assign bus.dbl_x     = r_qx;
    assign bus.dbl_y     = r_qy;
    assign bus.dbl_z     = r_qz;
    assign bus.add_start = (r_state == S_ADD_GO);
    assign bus.add_x0    = r_qx;
    assign bus.add_y0    = r_qy;
    assign bus.add_z0    = r_qz;
    assign bus.add_x1    = r_px;
    assign bus.add_y1    = r_py;
endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl: abstract point units where doubling is x2 on (x,y) and
// z+1, addition is coordinate-wise sum with P, so the result of k*P is simply k*(px,py).
module tb_ecc_scalar_mult_ctrl;
    localparam int M       = 163;
    localparam int TIMEOUT = 255;
    localparam int BUDGET  = 20000;
    typedef logic [M-1:0] word_t;
    localparam word_t GX = 163'h3F0EBA16286A2D57EA0991168D4994637E8343E36;
    localparam word_t GY = 163'h0D51FBC6C71A0094FA2CDD545B11C5C0C797324F1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ecc_scalar_mult_ctrl_if #(.M(M)) bus ();
    ecc_scalar_mult_ctrl #(.M(M), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        byte   kind;
        int    t_start;
        word_t ix, iy, iz, ax1, ay1, ox, oy, oz;
        bit    stable;
        bit    finished;
    } unit_op_t;

    unit_op_t ulog[$];
    unit_op_t stub_e;
    int stub_lat = 20;
    bit dbl_hang = 1'b0;
    int dbl_cnt, add_cnt, dbl_idx, add_idx;
    bit dbl_run = 1'b0, add_run = 1'b0;

    // Both unit stubs live in one process so the log has a single writer.
    always @(negedge clk) begin
        bus.dbl_done = 1'b0;
        bus.add_done = 1'b0;
        if (rst) begin
            dbl_run = 1'b0;
            add_run = 1'b0;
        end else begin
            if (dbl_run) begin
                dbl_cnt--;
                if (dbl_cnt == 0) begin
                    ulog[dbl_idx].stable   = ({bus.dbl_x, bus.dbl_y, bus.dbl_z} ===
                        {ulog[dbl_idx].ix, ulog[dbl_idx].iy, ulog[dbl_idx].iz});
                    ulog[dbl_idx].finished = 1'b1;
                    bus.dbl_xo   = ulog[dbl_idx].ox;
                    bus.dbl_yo   = ulog[dbl_idx].oy;
                    bus.dbl_zo   = ulog[dbl_idx].oz;
                    bus.dbl_done = 1'b1;
                    dbl_run      = 1'b0;
                end
            end else if (bus.dbl_start === 1'b1) begin
                stub_e.kind = "D";
                stub_e.t_start = cyc;
                stub_e.ix = bus.dbl_x;
                stub_e.iy = bus.dbl_y;
                stub_e.iz = bus.dbl_z;
                stub_e.ax1 = '0;
                stub_e.ay1 = '0;
                stub_e.ox = bus.dbl_x << 1;
                stub_e.oy = bus.dbl_y << 1;
                stub_e.oz = bus.dbl_z + word_t'(1);
                stub_e.stable = 1'b0;
                stub_e.finished = 1'b0;
                ulog.push_back(stub_e);
                dbl_idx = ulog.size() - 1;
                if (!dbl_hang) begin
                    dbl_run = 1'b1;
                    dbl_cnt = stub_lat;
                end
            end
            if (add_run) begin
                add_cnt--;
                if (add_cnt == 0) begin
                    ulog[add_idx].stable   = ({bus.add_x0, bus.add_y0, bus.add_z0,
                        bus.add_x1, bus.add_y1} === {ulog[add_idx].ix, ulog[add_idx].iy,
                        ulog[add_idx].iz, ulog[add_idx].ax1, ulog[add_idx].ay1});
                    ulog[add_idx].finished = 1'b1;
                    bus.add_x2   = ulog[add_idx].ox;
                    bus.add_y2   = ulog[add_idx].oy;
                    bus.add_z2   = ulog[add_idx].oz;
                    bus.add_done = 1'b1;
                    add_run      = 1'b0;
                end
            end else if (bus.add_start === 1'b1) begin
                stub_e.kind = "A";
                stub_e.t_start = cyc;
                stub_e.ix = bus.add_x0;
                stub_e.iy = bus.add_y0;
                stub_e.iz = bus.add_z0;
                stub_e.ax1 = bus.add_x1;
                stub_e.ay1 = bus.add_y1;
                stub_e.ox = bus.add_x0 + bus.add_x1;
                stub_e.oy = bus.add_y0 + bus.add_y1;
                stub_e.oz = bus.add_z0;
                stub_e.stable = 1'b0;
                stub_e.finished = 1'b0;
                ulog.push_back(stub_e);
                add_idx = ulog.size() - 1;
                add_run = 1'b1;
                add_cnt = stub_lat;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input word_t got, input word_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %s (len %0d) expected %s (len %0d)", name,
                      (got.len() > 80) ? got.substr(0, 79) : got, got.len(),
                      (exp.len() > 80) ? exp.substr(0, 79) : exp, exp.len());
    endtask

    function automatic word_t rand_word();
        word_t w;
        w = '0;
        for (int i = 0; i < 6; i++) w = {w[M-33:0], $urandom()};
        return w;
    endfunction

    // Reference: k*P with abstract units, derived from the bits of k.
    task automatic model(input word_t k, input word_t px, input word_t py, output bit inf,
                         output word_t x, output word_t y, output word_t z, output string ord);
        int n;
        n = -1;
        ord = "";
        for (int i = 0; i < M; i++) if (k[i]) n = i;
        if (n < 0) begin
            inf = 1'b1;
            x = word_t'(1);
            y = '0;
            z = '0;
        end else begin
            inf = 1'b0;
            x = k * px;
            y = k * py;
            z = word_t'(n + 1);
            for (int i = n - 1; i >= 0; i--) begin
                ord = {ord, "D"};
                if (k[i]) ord = {ord, "A"};
            end
        end
    endtask

    task automatic run_op(input word_t k, input word_t px, input word_t py, input int junk_every,
                          output int t0, output int td, output int base);
        base = ulog.size();
        @(negedge clk);
        bus.start = 1'b1;
        bus.k = k;
        bus.px = px;
        bus.py = py;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.k = rand_word();
        bus.px = rand_word();
        bus.py = rand_word();
        check("busy_rise", word_t'(bus.busy), word_t'(1));
        for (int n = 1; n < BUDGET && bus.done !== 1'b1; n++) begin
            bus.start = (junk_every > 0) && (n % junk_every == 0);
            if (bus.start) bus.k = rand_word();
            @(negedge clk);
        end
        bus.start = 1'b0;
        td = cyc;
        check("done_seen", word_t'(bus.done), word_t'(1));
        check("busy_at_done", word_t'(bus.busy), word_t'(0));
        @(negedge clk);
        check("idle_busy", word_t'(bus.busy), word_t'(0));
        check("idle_done", word_t'(bus.done), word_t'(0));
    endtask

    task automatic verify(input string tag, input int base, input word_t px, input word_t py,
                          input bit einf, input word_t ex, input word_t ey, input word_t ez,
                          input string eord);
        string ord;
        int bad;
        word_t qx, qy, qz;
        ord = "";
        bad = 0;
        qx = px;
        qy = py;
        qz = word_t'(1);
        for (int j = base; j < ulog.size(); j++) begin
            if (ulog[j].kind == "D") begin
                ord = {ord, "D"};
            end else begin
                ord = {ord, "A"};
                if (ulog[j].ax1 !== px || ulog[j].ay1 !== py) bad++;
            end
            if (ulog[j].ix !== qx || ulog[j].iy !== qy || ulog[j].iz !== qz) bad++;
            if (!ulog[j].stable || !ulog[j].finished) bad++;
            qx = ulog[j].ox;
            qy = ulog[j].oy;
            qz = ulog[j].oz;
        end
        check({tag, ".inf"}, word_t'(bus.inf), word_t'(einf));
        check({tag, ".err"}, word_t'(bus.err), word_t'(0));
        check({tag, ".x"}, bus.x_out, ex);
        check({tag, ".y"}, bus.y_out, ey);
        check({tag, ".z"}, bus.z_out, ez);
        check_str({tag, ".order"}, ord, eord);
        check({tag, ".operands"}, word_t'(bad), word_t'(0));
    endtask

    typedef struct {
        word_t k;
        int    lat;
        bit    einf;
        word_t ex, ey, ez;
        string eord;
        int    ecyc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0, td, base;
        bit minf;
        word_t mx, my, mz, k, px, py;
        string mord;
        bit seen;

        bus.start = 1'b0;
        bus.k = '0;
        bus.px = '0;
        bus.py = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", word_t'(bus.busy), '0);
        check("rst.done", word_t'(bus.done), '0);
        check("rst.inf", word_t'(bus.inf), '0);
        check("rst.err", word_t'(bus.err), '0);
        check("rst.dbl_start", word_t'(bus.dbl_start), '0);
        check("rst.add_start", word_t'(bus.add_start), '0);
        check("rst.x_out", bus.x_out, '0);
        check("rst.dbl_x", bus.dbl_x, '0);
        check("rst.add_x1", bus.add_x1, '0);
        rst = 1'b0;

        vecs[0] = '{word_t'(0), 20, 1'b1, word_t'(1), '0, '0, "", 164};
        vecs[1] = '{word_t'(1), 20, 1'b0, GX, GY, word_t'(1), "", 164};
        vecs[2] = '{word_t'(11), 20, 1'b0, GX * word_t'(11), GY * word_t'(11), word_t'(4),
                    "DDADA", 0};
        vecs[3] = '{word_t'(2), 3, 1'b0, GX << 1, GY << 1, word_t'(2), "D", 0};
        vecs[4] = '{word_t'(3), 1, 1'b0, GX * word_t'(3), GY * word_t'(3), word_t'(2), "DA", 0};
        for (int v = 0; v < 5; v++) begin
            stub_lat = vecs[v].lat;
            run_op(vecs[v].k, GX, GY, 0, t0, td, base);
            verify($sformatf("vec%0d", v), base, GX, GY, vecs[v].einf, vecs[v].ex, vecs[v].ey,
                   vecs[v].ez, vecs[v].eord);
            if (vecs[v].ecyc > 0) check($sformatf("vec%0d.latency", v), word_t'(td - t0),
                                        word_t'(vecs[v].ecyc));
        end

        for (int r = 0; r < 6; r++) begin
            if (r < 2) begin
                k = rand_word();
                k[M-1] = 1'b1;
            end else begin
                k = word_t'($urandom_range(1, 4095));
            end
            px = rand_word();
            py = rand_word();
            stub_lat = $urandom_range(1, 8);
            run_op(k, px, py, 0, t0, td, base);
            model(k, px, py, minf, mx, my, mz, mord);
            verify($sformatf("rand%0d", r), base, px, py, minf, mx, my, mz, mord);
        end

        // Start pulses while busy must not disturb the captured request.
        stub_lat = 20;
        k = word_t'(45);
        px = rand_word();
        py = rand_word();
        run_op(k, px, py, 5, t0, td, base);
        model(k, px, py, minf, mx, my, mz, mord);
        verify("busy_start", base, px, py, minf, mx, my, mz, mord);

        // Doubler never answers.
        dbl_hang = 1'b1;
        run_op(word_t'(2), GX, GY, 0, t0, td, base);
        dbl_hang = 1'b0;
        check("tmo.err", word_t'(bus.err), word_t'(1));
        check("tmo.latency", word_t'(td - ulog[base].t_start), word_t'(TIMEOUT + 1));
        check("tmo.x", bus.x_out, GX);
        check("tmo.z", bus.z_out, word_t'(1));

        // Reset in the middle of an add.
        stub_lat = 30;
        seen = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.k = word_t'(3);
        bus.px = GX;
        bus.py = GY;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            if (bus.add_start === 1'b1) seen = 1'b1;
        end
        check("rst_mid.add_seen", word_t'(seen), word_t'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.busy", word_t'(bus.busy), '0);
        check("rst_mid.done", word_t'(bus.done), '0);
        check("rst_mid.err", word_t'(bus.err), '0);
        check("rst_mid.add_start", word_t'(bus.add_start), '0);
        check("rst_mid.x_out", bus.x_out, '0);
        check("rst_mid.z_out", bus.z_out, '0);
        check("rst_mid.add_x0", bus.add_x0, '0);
        check("rst_mid.add_x1", bus.add_x1, '0);
        check("rst_mid.dbl_z", bus.dbl_z, '0);
        rst = 1'b0;
        stub_lat = 20;
        run_op(word_t'(2), GX, GY, 0, t0, td, base);
        verify("after_rst", base, GX, GY, 1'b0, GX << 1, GY << 1, word_t'(2), "D");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
